multisim_apb_channel_fsm: RTL and testbench

Synthesizable APB subordinate front-end for multisim server links. It tracks the APB transfer phase with a three-state FSM and forwards each APB request onto a valid/ready push channel. It then holds the bus in ACCESS until one response arrives on a valid/ready pull channel, and drives PREADY and response data from that response. It sits between an APB manager and the multisim request/response transport.

---
 rtl/multisim_apb_channel_fsm_pkg.sv | 12 +
 rtl/multisim_apb_channel_fsm_if.sv | 32 +++
 rtl/multisim_apb_channel_fsm_phase.sv | 33 +++
 rtl/multisim_apb_channel_fsm.sv | 97 +++++++++
 tb/tb_multisim_apb_channel_fsm.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/multisim_apb_channel_fsm_pkg.sv
// Shared types for the multisim APB channel front-end.
//   multisim_apb_state_t : APB transfer phase (IDLE, SETUP, ACCESS).
//                          Encoding 2'd3 is unused; the FSM treats it as IDLE.
package multisim_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } multisim_apb_state_t;

endpackage

// File: rtl/multisim_apb_channel_fsm_if.sv
// Bus bundle for multisim_apb_channel_fsm.
// It groups the APB side (request word, PSEL, PENABLE, PREADY, response word),
// the request push channel (valid/ready/data) and the response pull channel
// (valid/ready/data).
//   slave  : view of the front-end (the DUT).
//   master : view of the APB manager and transport (the environment).
interface multisim_apb_channel_fsm_if #(
  parameter int REQ_WIDTH  = 64,
  parameter int RESP_WIDTH = 34
);
  logic [REQ_WIDTH-1:0]  i_apb_req;
  logic                  i_psel;
  logic                  i_penable;
  logic                  o_pready;
  logic [RESP_WIDTH-1:0] o_apb_resp;
  logic                  o_req_vld;
  logic                  i_req_rdy;
  logic [REQ_WIDTH-1:0]  o_req_data;
  logic                  i_resp_vld;
  logic                  o_resp_rdy;
  logic [RESP_WIDTH-1:0] i_resp_data;

  modport slave (
    input  i_apb_req, i_psel, i_penable, i_req_rdy, i_resp_vld, i_resp_data,
    output o_pready, o_apb_resp, o_req_vld, o_req_data, o_resp_rdy
  );

  modport master (
    output i_apb_req, i_psel, i_penable, i_req_rdy, i_resp_vld, i_resp_data,
    input  o_pready, o_apb_resp, o_req_vld, o_req_data, o_resp_rdy
  );
endinterface

// File: rtl/multisim_apb_channel_fsm_phase.sv
// APB phase tracker: state register and next-state logic.
//   clk, rst : clock, asynchronous active-high reset
//   psel     : APB PSEL, starts a transfer from IDLE
//   pready   : completion of the ACCESS phase
//   abort    : manager dropped PSEL mid-transfer
//   hold     : blocks leaving IDLE while a stale response is still owed
//   state    : current phase
module multisim_apb_phase_fsm
  import multisim_apb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                psel,
  input  logic                pready,
  input  logic                abort,
  input  logic                hold,
  output multisim_apb_state_t state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        SETUP:   state <= abort ? IDLE : ACCESS;
        ACCESS:  if (abort || pready) state <= IDLE;
        // IDLE and the unused encoding both wait for a new transfer
        default: state <= (psel && !hold) ? SETUP : IDLE;
      endcase
    end
  end

endmodule

// File: rtl/multisim_apb_channel_fsm.sv
// APB subordinate front-end for multisim server links.
// Each APB transfer is pushed as one request word onto the request channel.
// ACCESS is then held until one word arrives on the response channel; that
// word drives PREADY and the APB response.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : APB + request/response channels (slave modport)
//   o_state  : current phase (0 IDLE, 1 SETUP, 2 ACCESS)
//   o_abort  : one-cycle pulse, coincident with the return to IDLE, when the
//              manager abandons a transfer
module multisim_apb_channel_fsm
  import multisim_apb_pkg::*;
#(
  parameter int REQ_WIDTH  = 64,
  parameter int RESP_WIDTH = 34
) (
  input  logic                      clk,
  input  logic                      rst,
  multisim_apb_channel_fsm_if.slave bus,
  output logic [1:0]                o_state,
  output logic                      o_abort
);

  multisim_apb_state_t   state;
  logic                  in_xfer;
  logic                  abort;
  logic                  req_vld;
  logic                  req_hs;
  logic                  pready;
  logic                  resp_rdy;
  logic                  start;
  logic                  req_sent;
  logic                  drain;
  logic                  abort_q;
  logic [REQ_WIDTH-1:0]  req_data_q;
  logic [RESP_WIDTH-1:0] resp_q;
  logic                  unused_penable;

  // PENABLE is monitored only; the phase is tracked from PSEL alone
  assign unused_penable = bus.i_penable;

  assign in_xfer = (state == SETUP) || (state == ACCESS);
  assign abort   = in_xfer && !bus.i_psel;
  assign start   = !in_xfer && bus.i_psel && !drain;
  assign req_vld = (state == SETUP) || ((state == ACCESS) && !req_sent);
  assign req_hs  = req_vld && bus.i_req_rdy;

  // Abort takes priority over a response in the same cycle: the response
  // stays on the channel and is later drained.
  assign pready   = bus.i_resp_vld && (state == ACCESS) && req_sent && !drain && !abort;
  assign resp_rdy = ((state == ACCESS) && req_sent && !abort) || drain;

  multisim_apb_phase_fsm u_phase (
    .clk    (clk),
    .rst    (rst),
    .psel   (bus.i_psel),
    .pready (pready),
    .abort  (abort),
    .hold   (drain),
    .state  (state)
  );

  // ---- control registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_sent <= 1'b0;
      drain    <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      abort_q <= abort;
      if (abort || pready) req_sent <= 1'b0;
      else if (req_hs)     req_sent <= 1'b1;
      // a request that reached the transport owes one response, which is swallowed
      if (abort && (req_sent || req_hs)) drain <= 1'b1;
      else if (drain && bus.i_resp_vld)  drain <= 1'b0;
    end
  end

  // ---- data registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_data_q <= '0;
      resp_q     <= '0;
    end else begin
      if (start)  req_data_q <= bus.i_apb_req;
      if (pready) resp_q     <= bus.i_resp_data;
    end
  end

  assign bus.o_req_vld  = req_vld;
  assign bus.o_req_data = req_data_q;
  assign bus.o_resp_rdy = resp_rdy;
  assign bus.o_pready   = pready;
  assign bus.o_apb_resp = pready ? bus.i_resp_data : resp_q;
  assign o_state        = state;
  assign o_abort        = abort_q;

endmodule

// File: tb/tb_multisim_apb_channel_fsm.sv
module tb_multisim_apb_channel_fsm;

  localparam int RW = 64;
  localparam int SW = 34;

  localparam logic [63:0] REQ1  = 64'h0000_1000_DEAD_BEEF;
  localparam logic [63:0] REQ2  = 64'h0000_2004_CAFE_F00D;
  localparam logic [63:0] REQ3  = 64'h8000_3008_0BAD_C0DE;
  localparam logic [63:0] REQ4  = 64'h0000_400C_1111_2222;
  localparam logic [63:0] REQ5  = 64'h8000_5010_3333_4444;
  localparam logic [63:0] REQ6  = 64'h0000_6014_5555_6666;
  localparam logic [63:0] REQ7  = 64'h8000_7018_7777_8888;
  localparam logic [63:0] REQ8  = 64'h0000_801C_9999_AAAA;
  localparam logic [63:0] EARLY = 64'h2_AAAA_5555;
  localparam logic [63:0] SLOW  = 64'h0_1234_5678;
  localparam logic [63:0] D4A   = 64'h3_0000_00A4;
  localparam logic [63:0] D4B   = 64'h3_0000_00B4;
  localparam logic [63:0] D5    = 64'h1_0000_0005;
  localparam logic [63:0] D7    = 64'h2_0000_0007;
  localparam logic [63:0] D8    = 64'h1_8888_0008;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] o_state;
  logic       o_abort;

  int n_vec  = 0;
  int n_err  = 0;
  int hs_cnt = 0;
  int hs0;

  logic [63:0] req_q[$];
  logic [63:0] resp_q[$];

  multisim_apb_channel_fsm_if #(.REQ_WIDTH(RW), .RESP_WIDTH(SW)) bus ();

  multisim_apb_channel_fsm #(.REQ_WIDTH(RW), .RESP_WIDTH(SW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (o_state),
    .o_abort (o_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: request words are matched on each request handshake,
  // response words on each PREADY cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_req_vld && bus.i_req_rdy) begin
        hs_cnt++;
        if (req_q.size() == 0) chk("req_unexpected", 64'd1, 64'd0);
        else                   chk("req_data", bus.o_req_data, req_q.pop_front());
      end
      if (bus.o_pready) begin
        if (resp_q.size() == 0) chk("pready_unexpected", 64'd1, 64'd0);
        else                    chk("apb_resp", bus.o_apb_resp, resp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_apb_req   = '0;
    bus.i_psel      = 1'b1;
    bus.i_penable   = 1'b0;
    bus.i_req_rdy   = 1'b1;
    bus.i_resp_vld  = 1'b1;
    bus.i_resp_data = '1;

    // reset state, with live inputs that must be ignored
    smp();
    chk("rst_state",     o_state, 0);
    chk("rst_req_vld",   bus.o_req_vld, 0);
    chk("rst_pready",    bus.o_pready, 0);
    chk("rst_resp_rdy",  bus.o_resp_rdy, 0);
    chk("rst_abort",     o_abort, 0);
    chk("rst_req_data",  bus.o_req_data, 0);
    chk("rst_apb_resp",  bus.o_apb_resp, 0);
    tick();
    rst = 1'b0;
    bus.i_psel = 1'b0;
    bus.i_resp_vld = 1'b0;

    // single write, always-ready channel
    tick();
    bus.i_psel = 1'b1; bus.i_penable = 1'b0; bus.i_apb_req = REQ1; bus.i_req_rdy = 1'b1;
    req_q.push_back(REQ1);
    hs0 = hs_cnt;
    smp(); chk("t1_c0_state", o_state, 0);
    tick(); bus.i_penable = 1'b1;
    smp(); chk("t1_c1_state", o_state, 1); chk("t1_c1_req_vld", bus.o_req_vld, 1);
    tick();
    bus.i_resp_vld = 1'b1; bus.i_resp_data = '0; resp_q.push_back(64'd0);
    smp();
    chk("t1_c2_state", o_state, 2); chk("t1_c2_pready", bus.o_pready, 1);
    chk("t1_req_data", bus.o_req_data, REQ1);
    tick();
    bus.i_psel = 1'b0; bus.i_penable = 1'b0; bus.i_resp_vld = 1'b0;
    smp();
    chk("t1_c3_state", o_state, 0); chk("t1_c3_pready", bus.o_pready, 0);
    chk("t1_hs_count", hs_cnt - hs0, 1);

    // request backpressure with an early response
    tick();
    bus.i_psel = 1'b1; bus.i_apb_req = REQ2; bus.i_req_rdy = 1'b0;
    req_q.push_back(REQ2);
    tick();
    bus.i_apb_req = ~REQ2;
    bus.i_resp_vld = 1'b1; bus.i_resp_data = EARLY[SW-1:0];
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("t2_req_vld",   bus.o_req_vld, 1);
      chk("t2_req_data",  bus.o_req_data, REQ2);
      chk("t2_resp_rdy",  bus.o_resp_rdy, 0);
      chk("t2_pready",    bus.o_pready, 0);
      chk("t2_resp_hold", bus.o_apb_resp, 0);
      tick();
    end
    bus.i_req_rdy = 1'b1;
    smp();
    chk("t2_acc_resp_rdy", bus.o_resp_rdy, 0); chk("t2_acc_pready", bus.o_pready, 0);
    tick();
    bus.i_req_rdy = 1'b0; resp_q.push_back(EARLY);
    smp();
    chk("t2_pready", bus.o_pready, 1); chk("t2_req_vld_low", bus.o_req_vld, 0);
    tick();
    bus.i_psel = 1'b0; bus.i_resp_vld = 1'b0;
    smp();
    chk("t2_end_state", o_state, 0); chk("t2_resp_held", bus.o_apb_resp, EARLY);

    // slow response
    tick();
    bus.i_psel = 1'b1; bus.i_apb_req = REQ3; bus.i_req_rdy = 1'b1;
    req_q.push_back(REQ3);
    tick();
    tick();
    bus.i_req_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      smp();
      chk("t3_wait_state", o_state, 2); chk("t3_wait_pready", bus.o_pready, 0);
      tick();
    end
    bus.i_resp_vld = 1'b1; bus.i_resp_data = SLOW[SW-1:0]; resp_q.push_back(SLOW);
    smp(); chk("t3_pready", bus.o_pready, 1);
    tick();
    bus.i_psel = 1'b0; bus.i_resp_vld = 1'b0; bus.i_resp_data = 34'h3_FFFF_0000;
    smp();
    chk("t3_end_state", o_state, 0); chk("t3_resp_held", bus.o_apb_resp, SLOW);

    // abort after send, colliding with a response
    tick();
    bus.i_psel = 1'b1; bus.i_apb_req = REQ4; bus.i_req_rdy = 1'b1;
    req_q.push_back(REQ4);
    tick();
    tick();
    bus.i_psel = 1'b0; bus.i_resp_vld = 1'b1; bus.i_resp_data = D4A[SW-1:0];
    smp();
    chk("t4_abort_pready", bus.o_pready, 0); chk("t4_abort_resp_rdy", bus.o_resp_rdy, 0);
    tick();
    bus.i_psel = 1'b1; bus.i_apb_req = REQ5; bus.i_resp_vld = 1'b0;
    req_q.push_back(REQ5);
    smp();
    chk("t4_idle_state", o_state, 0); chk("t4_abort_pulse", o_abort, 1);
    tick();
    smp();
    chk("t4_holdoff_state", o_state, 0); chk("t4_abort_low", o_abort, 0);
    tick();
    bus.i_resp_vld = 1'b1; bus.i_resp_data = D4B[SW-1:0];
    smp();
    chk("t4_drain_resp_rdy", bus.o_resp_rdy, 1); chk("t4_drain_pready", bus.o_pready, 0);
    chk("t4_drain_state", o_state, 0); chk("t4_drain_resp", bus.o_apb_resp, SLOW);
    tick();
    bus.i_resp_vld = 1'b0;
    smp(); chk("t4_post_drain_state", o_state, 0);
    tick();
    smp(); chk("t4_new_setup", o_state, 1);
    tick();
    bus.i_resp_vld = 1'b1; bus.i_resp_data = D5[SW-1:0]; resp_q.push_back(D5);
    smp(); chk("t4_new_pready", bus.o_pready, 1);
    tick();
    bus.i_psel = 1'b0; bus.i_resp_vld = 1'b0;
    smp(); chk("t4_end_state", o_state, 0);

    // abort before send
    tick();
    bus.i_psel = 1'b1; bus.i_apb_req = REQ6; bus.i_req_rdy = 1'b0;
    tick();
    bus.i_psel = 1'b0;
    smp(); chk("t5_setup_state", o_state, 1); chk("t5_setup_req_vld", bus.o_req_vld, 1);
    tick();
    bus.i_psel = 1'b1; bus.i_apb_req = REQ7; bus.i_req_rdy = 1'b1;
    req_q.push_back(REQ7);
    smp();
    chk("t5_idle_state", o_state, 0); chk("t5_abort_pulse", o_abort, 1);
    chk("t5_req_vld_low", bus.o_req_vld, 0); chk("t5_resp_rdy", bus.o_resp_rdy, 0);
    tick();
    smp(); chk("t5_next_setup", o_state, 1); chk("t5_req_data", bus.o_req_data, REQ7);
    tick();
    bus.i_resp_vld = 1'b1; bus.i_resp_data = D7[SW-1:0]; resp_q.push_back(D7);
    smp(); chk("t5_pready", bus.o_pready, 1);
    tick();
    bus.i_psel = 1'b0; bus.i_resp_vld = 1'b0;
    smp(); chk("t5_end_state", o_state, 0);

    // asynchronous reset in ACCESS
    tick();
    bus.i_psel = 1'b1; bus.i_apb_req = REQ8; bus.i_req_rdy = 1'b1;
    req_q.push_back(REQ8);
    tick();
    tick();
    smp(); chk("t6_pre_state", o_state, 2);
    #2 rst = 1'b1;
    #1;
    chk("t6_state",     o_state, 0);
    chk("t6_req_vld",   bus.o_req_vld, 0);
    chk("t6_pready",    bus.o_pready, 0);
    chk("t6_resp_rdy",  bus.o_resp_rdy, 0);
    chk("t6_abort",     o_abort, 0);
    chk("t6_req_data",  bus.o_req_data, 0);
    chk("t6_apb_resp",  bus.o_apb_resp, 0);
    tick();
    rst = 1'b0; bus.i_psel = 1'b0;
    bus.i_resp_vld = 1'b1; bus.i_resp_data = D8[SW-1:0];
    smp();
    chk("t6_no_drain", bus.o_resp_rdy, 0); chk("t6_no_pready", bus.o_pready, 0);
    chk("t6_idle", o_state, 0);
    tick();
    bus.i_resp_vld = 1'b0;

    smp();
    chk("req_q_empty",  req_q.size(), 0);
    chk("resp_q_empty", resp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
